alu_issue_ctrl: RTL and testbench

- Upstream issue stage for the 8-bit combinational `alu`. Buffers operation commands in a small FIFO and drives `A`/`B`/`ALU_Sel` from registers, one command at a time.
- Captures `ALU_Out`/`CarryOut` into a result register and presents it on a valid/ready result port.
- Isolates the purely combinational ALU from producer and consumer timing.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_issue_ctrl_if.sv | 35 +++
 rtl/alu.sv | 41 ++++
 rtl/alu_issue_ctrl_cmd_fifo.sv | 58 +++++
 rtl/alu_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
//   ALU_ADD / ALU_SUB : op selects the issue logic and bench rely on
//   state_e           : issue FSM state encoding
//   cmd_t / CMD_W     : one buffered command {a, b, sel}
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned CMD_W = 20;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } cmd_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the command, ALU-side and result signals of alu_issue_ctrl.
//   master : environment (command producer, alu, result consumer)
//   slave  : alu_issue_ctrl
interface alu_issue_ctrl_if #(
  parameter int unsigned LVL_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [3:0]       cmd_sel;
  logic [7:0]       A;
  logic [7:0]       B;
  logic [3:0]       ALU_Sel;
  logic [7:0]       ALU_Out;
  logic             CarryOut;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_carry;
  logic [LVL_W-1:0] fifo_level;
  logic             busy;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, ALU_Out, CarryOut, res_ready,
    input  cmd_ready, A, B, ALU_Sel, res_valid, res_data, res_carry,
           fifo_level, busy
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, ALU_Out, CarryOut, res_ready,
    output cmd_ready, A, B, ALU_Sel, res_valid, res_data, res_carry,
           fifo_level, busy
  );
endinterface

// File: rtl/alu.sv
// 8-bit combinational ALU driven by alu_issue_ctrl.
//   A, B     : operands
//   ALU_Sel  : operation select
//   ALU_Out  : result (low 8 bits)
//   CarryOut : carry of A+B, independent of the selected operation
module alu
  import alu_pkg::*;
(
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] ALU_Sel,
  output logic [7:0] ALU_Out,
  output logic       CarryOut
);
  logic [8:0] sum;

  assign sum      = {1'b0, A} + {1'b0, B};
  assign CarryOut = sum[8];

  always_comb begin
    ALU_Out = sum[7:0];
    case (ALU_Sel)
      ALU_ADD: ALU_Out = sum[7:0];
      ALU_SUB: ALU_Out = A - B;
      4'd2:    ALU_Out = A * B;
      4'd3:    ALU_Out = (B == '0) ? '1 : A / B;
      4'd4:    ALU_Out = A << 1;
      4'd5:    ALU_Out = A >> 1;
      4'd6:    ALU_Out = {A[6:0], A[7]};
      4'd7:    ALU_Out = {A[0], A[7:1]};
      4'd8:    ALU_Out = A & B;
      4'd9:    ALU_Out = A | B;
      4'd10:   ALU_Out = A ^ B;
      4'd11:   ALU_Out = ~(A | B);
      4'd12:   ALU_Out = ~(A & B);
      4'd13:   ALU_Out = ~(A ^ B);
      4'd14:   ALU_Out = (A > B) ? 8'd1 : 8'd0;
      default: ALU_Out = (A == B) ? 8'd1 : 8'd0;
    endcase
  end
endmodule

// File: rtl/alu_issue_ctrl_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x CMD_W, no bypass.
//   push_i / din_i   : write request and data (ignored when full)
//   pop_i / dout_o   : read request and head entry (ignored when empty)
//   full_o / empty_o : status from the registered count
//   level_o          : entries currently stored, 0..DEPTH
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [CMD_W-1:0] din_i,
  input  logic             pop_i,
  output logic [CMD_W-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LVL_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the combinational alu: buffers commands, drives
// A/B/ALU_Sel from registers one command at a time, captures the result
// and offers it on a valid/ready port.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : command port (cmd_*), alu operands/result (A, B, ALU_Sel,
//              ALU_Out, CarryOut), result port (res_*), status
//              (fifo_level, busy)
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  alu_issue_ctrl_if.slave bus
);
  state_e           state_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [3:0]       sel_q;
  logic [7:0]       res_data_q;
  logic             res_carry_q;
  logic             res_valid_q;
  logic             busy_q;
  logic             rdy_en_q;

  cmd_t             push_cmd;
  cmd_t             head;
  logic [CMD_W-1:0] head_raw;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             push;
  logic             pop;

  assign push_cmd = '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel};
  assign head     = cmd_t'(head_raw);

  // rdy_en_q holds cmd_ready low during reset and for the remainder of the
  // cycle in which reset is released.
  assign bus.cmd_ready = rdy_en_q && !fifo_full;
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop  = !fifo_empty &&
                ((state_q == IDLE) || ((state_q == RESP) && bus.res_ready));

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_cmd),
    .pop_i   (pop),
    .dout_o  (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= '0;
    end else if (pop) begin
      a_q   <= head.a;
      b_q   <= head.b;
      sel_q <= head.sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= EXEC;
            busy_q  <= 1'b1;
          end
        end
        EXEC: begin
          res_data_q  <= bus.ALU_Out;
          res_carry_q <= bus.CarryOut;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              state_q <= EXEC;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.A          = a_q;
  assign bus.B          = b_q;
  assign bus.ALU_Sel    = sel_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_carry  = res_carry_q;
  assign bus.fifo_level = fifo_level;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int unsigned checks = 0;
  int unsigned failures = 0;

  alu_issue_ctrl_if #(.LVL_W(3)) bus ();

  alu u_alu (
    .A        (bus.A),
    .B        (bus.B),
    .ALU_Sel  (bus.ALU_Sel),
    .ALU_Out  (bus.ALU_Out),
    .CarryOut (bus.CarryOut)
  );

  alu_issue_ctrl #(.DEPTH(4), .LVL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_result(input logic [7:0] exp_d, input logic exp_c, input bit ck_c,
                            input string tag);
    int unsigned n = 0;
    bus.res_ready = 1'b1;
    while (!bus.res_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, bus.res_valid, 1);
    chk({tag, "_data"}, bus.res_data, exp_d);
    if (ck_c) chk({tag, "_carry"}, bus.res_carry, exp_c);
    tick();
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                         input logic [7:0] exp_d, input logic exp_c, input bit ck_c,
                         input string tag);
    chk({tag, "_rdy"}, bus.cmd_ready, 1);
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_sel = sel; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    get_result(exp_d, exp_c, ck_c, tag);
  endtask

  logic [7:0] bp_a [5] = '{8'h01, 8'h10, 8'h80, 8'h05, 8'h7F};
  logic [7:0] bp_b [5] = '{8'h02, 8'h01, 8'h80, 8'h07, 8'h01};
  logic [3:0] bp_s [5] = '{ALU_ADD, ALU_SUB, ALU_ADD, ALU_SUB, ALU_ADD};
  logic [7:0] bp_r [5] = '{8'h03, 8'h0F, 8'h00, 8'hFE, 8'h80};

  logic [7:0] ra [10];
  logic [7:0] rb [10];
  logic [3:0] rs [10];
  logic [7:0] rr [10];

  initial begin
    int unsigned idx;
    int unsigned k;
    int unsigned pi;
    int unsigned ri;
    bit acc;

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_sel = '0;
    bus.res_ready = 1'b0;
    tick();
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_A", bus.A, 0);
    rst = 1'b0;
    chk("rel_cmd_ready_lo", bus.cmd_ready, 0);
    tick();
    chk("rel_cmd_ready_hi", bus.cmd_ready, 1);

    // Single ADD with cycle-accurate timing
    bus.res_ready = 1'b1;
    bus.cmd_a = 8'h3C; bus.cmd_b = 8'h14; bus.cmd_sel = ALU_ADD; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("t1_level", bus.fifo_level, 1);
    chk("t1_busy0", bus.busy, 0);
    chk("t1_valid0", bus.res_valid, 0);
    tick();
    chk("t1_A", bus.A, 8'h3C);
    chk("t1_B", bus.B, 8'h14);
    chk("t1_sel", bus.ALU_Sel, 0);
    chk("t1_busy1", bus.busy, 1);
    chk("t1_valid1", bus.res_valid, 0);
    chk("t1_level0", bus.fifo_level, 0);
    tick();
    chk("t1_valid2", bus.res_valid, 1);
    chk("t1_data", bus.res_data, 8'h50);
    chk("t1_carry", bus.res_carry, 0);
    tick();
    chk("t1_valid3", bus.res_valid, 0);
    chk("t1_busy3", bus.busy, 0);
    chk("t1_hold", bus.res_data, 8'h50);

    run_one(8'hFF, 8'h01, ALU_ADD, 8'h00, 1'b1, 1'b1, "add_wrap");
    run_one(8'h10, 8'h20, ALU_SUB, 8'hF0, 1'b0, 1'b0, "sub_neg");
    chk("sub_A", bus.A, 8'h10);
    chk("sub_sel", bus.ALU_Sel, ALU_SUB);

    // Backpressure: fill RESP + FIFO
    bus.res_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      k = (idx < 5) ? idx : 4;
      bus.cmd_a = bp_a[k]; bus.cmd_b = bp_b[k]; bus.cmd_sel = bp_s[k];
      bus.cmd_valid = 1'b1;
      acc = bus.cmd_ready;
      tick();
      if (acc) idx++;
    end
    bus.cmd_valid = 1'b0;
    chk("bp_accepted", idx, 5);
    chk("bp_cmd_ready", bus.cmd_ready, 0);
    chk("bp_level", bus.fifo_level, 4);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid%0d", i), bus.res_valid, 1);
      chk($sformatf("bp_data%0d", i), bus.res_data, bp_r[i]);
      chk($sformatf("bp_lvl%0d", i), bus.fifo_level, 4 - i);
      bus.res_ready = 1'b1;
      tick();
      chk($sformatf("bp_gap%0d", i), bus.res_valid, 0);
      chk($sformatf("bp_busy%0d", i), bus.busy, (i < 4) ? 1 : 0);
      if (i < 4) tick();
    end

    // Simultaneous push and pop at level 2
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 8'h20; bus.cmd_b = 8'h22; bus.cmd_sel = ALU_ADD; tick();
    bus.cmd_a = 8'h50; bus.cmd_b = 8'h10; bus.cmd_sel = ALU_SUB; tick();
    bus.cmd_a = 8'hAA; bus.cmd_b = 8'h11; bus.cmd_sel = ALU_ADD; tick();
    chk("pp_level_pre", bus.fifo_level, 2);
    chk("pp_valid", bus.res_valid, 1);
    chk("pp_d0", bus.res_data, 8'h42);
    bus.cmd_a = 8'h00; bus.cmd_b = 8'h01; bus.cmd_sel = ALU_SUB;
    bus.res_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("pp_level_post", bus.fifo_level, 2);
    chk("pp_valid_post", bus.res_valid, 0);
    get_result(8'h40, 1'b0, 1'b0, "pp_d1");
    get_result(8'hBB, 1'b0, 1'b0, "pp_d2");
    get_result(8'hFF, 1'b0, 1'b0, "pp_d3");

    // Random stream with random consumer backpressure
    for (int i = 0; i < 10; i++) begin
      ra[i] = 8'($urandom_range(0, 255));
      rb[i] = 8'($urandom_range(0, 255));
      rs[i] = ($urandom_range(0, 1) == 0) ? ALU_ADD : ALU_SUB;
      rr[i] = (rs[i] == ALU_SUB) ? 8'(ra[i] - rb[i]) : 8'(ra[i] + rb[i]);
    end
    pi = 0;
    ri = 0;
    for (int c = 0; c < 400 && ri < 10; c++) begin
      bus.cmd_valid = (pi < 10);
      if (pi < 10) begin
        bus.cmd_a = ra[pi]; bus.cmd_b = rb[pi]; bus.cmd_sel = rs[pi];
      end
      bus.res_ready = 1'($urandom_range(0, 1));
      acc = bus.cmd_valid && bus.cmd_ready;
      if (bus.res_valid && bus.res_ready) begin
        chk($sformatf("rnd_res%0d", ri), bus.res_data, rr[ri]);
        ri++;
      end
      tick();
      if (acc) pi++;
    end
    bus.cmd_valid = 1'b0;
    chk("rnd_count", ri, 10);

    // Asynchronous reset in RESP with level 3
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 8'h11; bus.cmd_b = 8'h22; bus.cmd_sel = ALU_ADD;
    for (int c = 0; c < 4; c++) tick();
    bus.cmd_valid = 1'b0;
    chk("ar_level_pre", bus.fifo_level, 3);
    chk("ar_valid_pre", bus.res_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", bus.res_valid, 0);
    chk("ar_level", bus.fifo_level, 0);
    chk("ar_A", bus.A, 0);
    chk("ar_B", bus.B, 0);
    chk("ar_sel", bus.ALU_Sel, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_data", bus.res_data, 0);
    chk("ar_cmd_ready", bus.cmd_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    run_one(8'h0A, 8'h0B, ALU_ADD, 8'h15, 1'b0, 1'b1, "post_rst");
    chk("post_rst_level", bus.fifo_level, 0);
    chk("post_rst_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
